tmds_decode: RTL

- Receive-side TMDS channel decoder for the HDMI/DVI path.
- Takes one deserialized 10-bit TMDS character per pixel clock and recovers the 8-bit pixel data, the data-enable flag and the control bits c0/c1.
- Runs a word-alignment state machine that requests bit-slips from the deserializer until control tokens are seen reliably.
- One instance per TMDS channel (blue/green/red), placed between the ISERDES/deserializer and the video timing recovery logic.

---
 rtl/tmds_pkg.sv | 37 +++
 rtl/tmds_word_align.sv | 112 +++++++++++
 rtl/tmds_decode.sv | 102 ++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token characters and word-alignment FSM states.
// The token constants are the same ones the transmit encoder emits during blanking.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctl;
    } tok_info_t;

    // ctl is {c1,c0}; hit is clear for any data character
    function automatic tok_info_t token_lookup(input logic [9:0] w);
        tok_info_t t;
        t.hit = 1'b1;
        t.ctl = 2'b00;
        case (w)
            TOK_C00: t.ctl = 2'b00;
            TOK_C01: t.ctl = 2'b01;
            TOK_C10: t.ctl = 2'b10;
            TOK_C11: t.ctl = 2'b11;
            default: t.hit = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-boundary alignment: watches the token flag, pulses bitslip until runs of
// control tokens appear, then holds lock until tokens go missing for too long.
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4095,
    parameter int SLIP_WAIT      = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_is_token,
    output logic o_bitslip,
    output logic o_aligned
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CTRL_RUN);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(SEARCH_TIMEOUT);
    localparam logic [WT_W-1:0]  WT_LAST = WT_W'(SLIP_WAIT - 1);

    align_state_t     r_state;
    logic [RUN_W-1:0] r_run;
    logic [TO_W-1:0]  r_to;
    logic [WT_W-1:0]  r_wait;
    logic             r_bitslip;
    logic             r_aligned;

    logic [RUN_W-1:0] w_run_next;
    logic [TO_W-1:0]  w_to_inc;
    logic             w_run_done;
    logic             w_to_expire;

    always_comb begin
        w_run_next = '0;
        if (i_is_token) begin
            w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
        end
    end

    // A saturated run keeps counting as complete while tokens keep coming
    assign w_run_done  = (w_run_next == RUN_MAX);
    assign w_to_inc    = r_to + TO_W'(1);
    assign w_to_expire = (w_to_inc == TO_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= SEARCH;
            r_run     <= '0;
            r_to      <= '0;
            r_wait    <= '0;
            r_bitslip <= 1'b0;
            r_aligned <= 1'b0;
        end else begin
            r_bitslip <= 1'b0;
            case (r_state)
                SEARCH: begin
                    r_run <= w_run_next;
                    if (w_run_done) begin
                        r_state   <= LOCKED;
                        r_aligned <= 1'b1;
                        r_to      <= '0;
                    end else if (w_to_expire) begin
                        r_state   <= SLIP;
                        r_bitslip <= 1'b1;
                        r_to      <= w_to_inc;
                    end else begin
                        r_to <= w_to_inc;
                    end
                end
                SLIP: begin
                    r_run   <= '0;
                    r_to    <= '0;
                    r_wait  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Deserializer output is still settling; tokens here are ignored
                    if (r_wait == WT_LAST) begin
                        r_wait  <= '0;
                        r_state <= SEARCH;
                    end else begin
                        r_wait <= r_wait + WT_W'(1);
                    end
                end
                LOCKED: begin
                    r_run <= w_run_next;
                    if (w_run_done) begin
                        r_to <= '0;
                    end else if (w_to_expire) begin
                        r_state   <= SEARCH;
                        r_aligned <= 1'b0;
                        r_run     <= '0;
                        r_to      <= '0;
                    end else begin
                        r_to <= w_to_inc;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign o_bitslip = r_bitslip;
    assign o_aligned = r_aligned;

endmodule

// File: rtl/tmds_decode.sv
// TMDS receive channel decoder: 10-bit character in, pixel byte / control bits out,
// two-stage pipeline with word alignment driven by the stage-1 token flag.
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 4095,
    parameter int SLIP_WAIT      = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] data_in,
    output logic [7:0] data_out,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       bitslip,
    output logic       aligned
);

    tok_info_t  w_tok;
    logic [9:0] r_s1_word;
    logic       r_s1_tok;
    logic [1:0] r_s1_ctl;

    logic [7:0] w_dp;
    logic [7:0] w_q;
    logic       w_aligned;
    logic       w_bitslip;

    logic [7:0] r_data_out;
    logic       r_de;
    logic       r_c0;
    logic       r_c1;

    assign w_tok = token_lookup(data_in);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_word <= '0;
            r_s1_tok  <= 1'b0;
            r_s1_ctl  <= 2'b00;
        end else begin
            r_s1_word <= data_in;
            r_s1_tok  <= w_tok.hit;
            r_s1_ctl  <= w_tok.ctl;
        end
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    assign w_dp   = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];
    assign w_q[0] = w_dp[0];

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_unchain
            assign w_q[gi] = r_s1_word[8] ? (w_dp[gi] ^ w_dp[gi-1])
                                          : ~(w_dp[gi] ^ w_dp[gi-1]);
        end
    endgenerate

    tmds_word_align #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) u_align (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i_is_token (r_s1_tok),
        .o_bitslip  (w_bitslip),
        .o_aligned  (w_aligned)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_data_out <= '0;
            r_de       <= 1'b0;
            r_c0       <= 1'b0;
            r_c1       <= 1'b0;
        end else if (r_s1_tok) begin
            r_data_out <= '0;
            r_de       <= 1'b0;
            r_c1       <= r_s1_ctl[1];
            r_c0       <= r_s1_ctl[0];
        end else if (w_aligned) begin
            r_data_out <= w_q;
            r_de       <= 1'b1;
        end else begin
            // Unaligned data is garbage; keep it off the video path
            r_data_out <= '0;
            r_de       <= 1'b0;
        end
    end

    assign data_out = r_data_out;
    assign de       = r_de;
    assign c0       = r_c0;
    assign c1       = r_c1;
    assign bitslip  = w_bitslip;
    assign aligned  = w_aligned;

endmodule
